// File: rtl/instr_encoder_pkg.sv
// Shared constants for the instruction encoder and decoder: format codes,
// opcode field position and encoder FSM states.
package instr_encoder_pkg;

    localparam int WORD_W    = 16;
    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 10;
    localparam int PAYLOAD_W = OPC_LSB;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_IMM  = 3'd1,
        FMT_MEM  = 3'd2,
        FMT_BR   = 3'd3,
        FMT_JMP  = 3'd4
    } fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// encodec_pack: combinational packing of decoded fields into a 16-bit word;
// flags format codes that have no defined payload.
module encodec_pack
    import instr_encoder_pkg::*;
(
    input  logic [5:0]        opcode,
    input  logic [2:0]        fmt,
    input  logic [1:0]        sel,
    input  logic [7:0]        inm,
    input  logic [9:0]        memdir,
    input  logic [3:0]        cond,
    input  logic [5:0]        branchdir,
    input  logic [9:0]        jmpdir,
    output logic [WORD_W-1:0] word,
    output logic              illegal
);

    logic [PAYLOAD_W-1:0] payload;

    always_comb begin
        payload = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_NONE: payload = '0;
            FMT_IMM:  payload = {sel, inm};
            FMT_MEM:  payload = memdir;
            FMT_BR:   payload = {cond, branchdir};
            FMT_JMP:  payload = jmpdir;
            default:  illegal = 1'b1;
        endcase
    end

    always_comb begin
        word = '0;
        word[OPC_MSB:OPC_LSB] = opcode;
        word[OPC_LSB-1:0]     = payload;
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams packed instruction words to program memory at sequential addresses.
// Define ENCODEC_CHECKSUM_EN to add a running XOR checksum of delivered words.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [5:0]        in_opcode,
    input  logic [2:0]        in_fmt,
    input  logic [1:0]        in_sel,
    input  logic [7:0]        in_inm,
    input  logic [9:0]        in_memdir,
    input  logic [3:0]        in_cond,
    input  logic [5:0]        in_branchdir,
    input  logic [9:0]        in_jmpdir,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              done,
`ifdef ENCODEC_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic              err
);

    generate
        if (DATA_W != WORD_W) begin : g_bad_width
            $error("instr_encoder: DATA_W must be 16");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    enc_state_t        state;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] word;
    logic              illegal;
    logic              accept;

    encodec_pack u_pack (
        .opcode    (in_opcode),
        .fmt       (in_fmt),
        .sel       (in_sel),
        .inm       (in_inm),
        .memdir    (in_memdir),
        .cond      (in_cond),
        .branchdir (in_branchdir),
        .jmpdir    (in_jmpdir),
        .word      (word),
        .illegal   (illegal)
    );

    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // A word loaded this cycle overrides the clearing of out_valid by the
    // handshake; start takes priority over a same-cycle checksum update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            addr      <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef ENCODEC_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
`ifdef ENCODEC_CHECKSUM_EN
                checksum  <= checksum ^ out_data;
`endif
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_RUN;
                        addr  <= base_addr;
                        err   <= 1'b0;
`ifdef ENCODEC_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (illegal) begin
                            err <= 1'b1;
                            if (in_last) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            out_valid <= 1'b1;
                            out_data  <= word;
                            out_addr  <= addr;
                            addr      <= addr + 1'b1;
                            // The write to the top address fills memory.
                            if (in_last || addr == ADDR_MAX) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder; checksum checks compile in only
// when ENCODEC_CHECKSUM_EN is defined.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [5:0]  in_opcode;
    logic [2:0]  in_fmt;
    logic [1:0]  in_sel;
    logic [7:0]  in_inm;
    logic [9:0]  in_memdir;
    logic [3:0]  in_cond;
    logic [5:0]  in_branchdir;
    logic [9:0]  in_jmpdir;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_addr;
    logic [15:0] out_data;
    logic        done;
    logic        err;
`ifdef ENCODEC_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(10), .DATA_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .in_opcode    (in_opcode),
        .in_fmt       (in_fmt),
        .in_sel       (in_sel),
        .in_inm       (in_inm),
        .in_memdir    (in_memdir),
        .in_cond      (in_cond),
        .in_branchdir (in_branchdir),
        .in_jmpdir    (in_jmpdir),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .done         (done),
`ifdef ENCODEC_CHECKSUM_EN
        .checksum     (checksum),
`endif
        .err          (err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic last, input logic [5:0] opc,
                                 input logic [2:0] fmt, input logic [9:0] operand);
        in_valid     = valid;
        in_last      = last;
        in_opcode    = opc;
        in_fmt       = fmt;
        in_sel       = operand[9:8];
        in_inm       = operand[7:0];
        in_memdir    = operand;
        in_cond      = operand[9:6];
        in_branchdir = operand[5:0];
        in_jmpdir    = operand;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startProgram(input logic [9:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 6'h00, 3'd0, 10'h000);
        repeat (2) tick();
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_addr", out_addr, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
`ifdef ENCODEC_CHECKSUM_EN
        checkOutput("rst_checksum", checksum, 0);
`endif
        reset = 1'b1;
        tick();
        checkOutput("idle_in_ready", in_ready, 0);

        // IMM then JMP-last
        startProgram(10'h000);
        checkOutput("run_in_ready", in_ready, 1);
        applyStimulus(1'b1, 1'b0, 6'h05, 3'd1, {2'd2, 8'hA5});
        tick();
        checkOutput("imm_valid", out_valid, 1);
        checkOutput("imm_data", out_data, 16'h16A5);
        checkOutput("imm_addr", out_addr, 10'h000);
        checkOutput("imm_done", done, 0);
        applyStimulus(1'b1, 1'b1, 6'h3F, 3'd4, 10'h3FF);
        tick();
        applyStimulus(1'b0, 1'b0, 6'h00, 3'd0, 10'h000);
        checkOutput("jmp_data", out_data, 16'hFFFF);
        checkOutput("jmp_addr", out_addr, 10'h001);
        checkOutput("jmp_done", done, 1);
        checkOutput("jmp_in_ready", in_ready, 0);
`ifdef ENCODEC_CHECKSUM_EN
        checkOutput("cks_first", checksum, 16'h16A5);
`endif
        tick();
        checkOutput("jmp_drained", out_valid, 0);
        checkOutput("jmp_done_pulse", done, 0);
`ifdef ENCODEC_CHECKSUM_EN
        checkOutput("cks_two", checksum, 16'hE95A);
`endif

        // memory-full wrap at the top address
        startProgram(10'h3FE);
`ifdef ENCODEC_CHECKSUM_EN
        checkOutput("cks_start_clr", checksum, 0);
`endif
        applyStimulus(1'b1, 1'b0, 6'h01, 3'd0, 10'h000);
        tick();
        checkOutput("full1_addr", out_addr, 10'h3FE);
        checkOutput("full1_data", out_data, 16'h0400);
        applyStimulus(1'b1, 1'b0, 6'h02, 3'd0, 10'h000);
        tick();
        checkOutput("full2_addr", out_addr, 10'h3FF);
        checkOutput("full2_data", out_data, 16'h0800);
        checkOutput("full2_done", done, 1);
        checkOutput("full2_in_ready", in_ready, 0);
        applyStimulus(1'b1, 1'b0, 6'h03, 3'd0, 10'h000);
        tick();
        checkOutput("full3_refused", out_valid, 0);
        checkOutput("full3_in_ready", in_ready, 0);
        applyStimulus(1'b0, 1'b0, 6'h00, 3'd0, 10'h000);

        // backpressure for three cycles
        startProgram(10'h010);
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 6'h0A, 3'd2, 10'h155);
        tick();
        applyStimulus(1'b1, 1'b0, 6'h0C, 3'd3, {4'h9, 6'h2A});
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_data", out_data, 16'h2955);
            checkOutput("bp_addr", out_addr, 10'h010);
            checkOutput("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", in_ready, 1);
        tick();
        checkOutput("br_data", out_data, 16'h326A);
        checkOutput("br_addr", out_addr, 10'h011);

        // illegal format drops the bundle and leaves the address alone
        applyStimulus(1'b1, 1'b0, 6'h11, 3'd6, 10'h0FF);
        tick();
        checkOutput("ill_err", err, 1);
        checkOutput("ill_no_valid", out_valid, 0);
        applyStimulus(1'b1, 1'b1, 6'h01, 3'd4, 10'h123);
        tick();
        applyStimulus(1'b0, 1'b0, 6'h00, 3'd0, 10'h000);
        checkOutput("after_ill_addr", out_addr, 10'h012);
        checkOutput("after_ill_data", out_data, 16'h0523);
        checkOutput("after_ill_done", done, 1);
        tick();
        startProgram(10'h000);
        checkOutput("start_clr_err", err, 0);

        // asynchronous reset with a word pending
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 6'h05, 3'd1, {2'd2, 8'hA5});
        tick();
        applyStimulus(1'b0, 1'b0, 6'h00, 3'd0, 10'h000);
        checkOutput("pend_valid", out_valid, 1);
        reset = 1'b0;
        #2;
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_in_ready", in_ready, 0);
        checkOutput("mid_rst_data", out_data, 0);
`ifdef ENCODEC_CHECKSUM_EN
        checkOutput("mid_rst_checksum", checksum, 0);
`endif
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        checkOutput("post_rst_idle", in_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
